cp0_unit: RTL and testbench

- Coprocessor 0 for the pipelined MIPS core; sits downstream of the CU decoder.
- Consumes the decoder's mfc0/mtc0/eret/syscall outcomes, as resolved in the M stage, plus the pipeline's exception code and the external hardware interrupt lines.
- Holds SR, Cause, EPC and PRId, and raises the exception/interrupt request that flushes the pipeline.
- Supplies EPC to the PC mux for the ERET selection.

---
 rtl/cp0_unit.sv | 140 ++++++++++++++
 tb/tb_cp0_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 holding SR, Cause, EPC and PRId; raises the exception/interrupt flush request.
// Latency: Req, Dout and EPCOut are combinational from current state; register writes are visible next cycle.
// Backpressure: none; when Req is high any mtc0 in the same cycle is discarded.
// Optional feature macro: CP0_TIMER_EN adds Count(9)/Compare(11) and a sticky timer interrupt on HWInt[5].
module cp0_unit #(
    parameter logic [31:0] PRID     = 32'h2024_0001,
    parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] Din,
    input  logic        we,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] Dout
);

    // SR fields
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    // Cause fields
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    // EPC
    logic [31:0] r_epc;

    logic [5:0]  w_hwint;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_wr_en;
    logic [31:0] w_epc_base;
    logic [31:0] w_epc_victim;
    logic [31:0] w_dout;

`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    // Timer interrupt shares line 5 with the external source.
    assign w_hwint = {HWInt[5] | r_ti, HWInt[4:0]};

    // Free-running Count, Compare register and sticky match flag; an mtc0 to Compare acknowledges the timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 32'h0;
            r_compare <= 32'h0;
            r_ti      <= 1'b0;
        end else begin
            if (w_wr_en && (A2 == 5'd9)) begin
                r_count <= Din;
            end else begin
                r_count <= r_count + 32'd1;
            end
            if (w_wr_en && (A2 == 5'd11)) begin
                r_compare <= Din;
                r_ti      <= 1'b0;
            end else if ((r_count == r_compare) && (r_compare != 32'h0)) begin
                r_ti <= 1'b1;
            end
        end
    end
`else
    assign w_hwint = HWInt;
`endif

    // Requests are masked entirely while EXL is set, so a pending eret never races a new exception.
    assign w_int_req = (|(w_hwint & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
    assign w_req     = w_int_req | w_exc_req;
    assign w_wr_en   = we & ~w_req;

    // A delay-slot victim restarts at its branch; the subtraction wraps modulo 2^32.
    assign w_epc_base   = BDIn ? (VPC - 32'd4) : VPC;
    assign w_epc_victim = {w_epc_base[31:2], 2'b00};

    // SR/Cause/EPC update: exception entry has priority over mtc0; eret clears EXL after any SR write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= SR_RESET[15:10];
            r_exl     <= SR_RESET[1];
            r_ie      <= SR_RESET[0];
            r_bd      <= 1'b0;
            r_ip      <= 6'h0;
            r_exccode <= 5'h0;
            r_epc     <= 32'h0;
        end else begin
            r_ip <= w_hwint;
            if (w_req) begin
                r_exl     <= 1'b1;
                r_bd      <= BDIn;
                r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
                r_epc     <= w_epc_victim;
            end else begin
                if (we && (A2 == 5'd12)) begin
                    r_im  <= Din[15:10];
                    r_exl <= Din[1];
                    r_ie  <= Din[0];
                end
                if (we && (A2 == 5'd14)) begin
                    r_epc <= Din;
                end
                if (EXLClr) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read mux; unmapped numbers read zero.
    always_comb begin
        w_dout = 32'h0;
        case (A1)
            5'd12:   w_dout = {16'h0, r_im, 8'h0, r_exl, r_ie};
            5'd13:   w_dout = {r_bd, 15'h0, r_ip, 3'h0, r_exccode, 2'b00};
            5'd14:   w_dout = r_epc;
            5'd15:   w_dout = PRID;
`ifdef CP0_TIMER_EN
            5'd9:    w_dout = r_count;
            5'd11:   w_dout = r_compare;
`endif
            default: w_dout = 32'h0;
        endcase
    end

    assign Req    = w_req;
    assign EPCOut = r_epc;
    assign Dout   = w_dout;

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed test-plan sequence plus randomized traffic against a word-level CP0 model.
// Latency: outputs compared every cycle at the falling edge; directed checks #1 after input changes.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_cp0_unit;

    localparam logic [31:0] PRID     = 32'h2024_0001;
    localparam logic [31:0] SR_RESET = 32'h0000_0000;
    localparam logic [31:0] SR_MASK  = 32'h0000_FC03;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] Din, VPC;
    logic        we, BDIn, EXLClr;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        Req;
    logic [31:0] EPCOut, Dout;

    int n_chk  = 0;
    int n_pass = 0;

    always #10 clk = ~clk;

    cp0_unit #(.PRID(PRID), .SR_RESET(SR_RESET)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .we(we),
        .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .Req(Req), .EPCOut(EPCOut), .Dout(Dout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model (whole-register words) ----------------
    logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
    logic        m_ti;
    logic        m_ok = 1'b0;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
`ifdef CP0_TIMER_EN
            5'd9:    return m_count;
            5'd11:   return m_compare;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // Compare DUT against model each cycle, then advance the model to the post-edge state.
    always @(negedge clk) begin
        logic [5:0]  hw;
        logic        ir, er, rq, wr;
        logic [31:0] nsr, ncause, nepc, ncount, ncompare, vict;
        logic        nti;
        if (reset) begin
            m_sr      = SR_RESET & SR_MASK;
            m_cause   = 32'h0;
            m_epc     = 32'h0;
            m_count   = 32'h0;
            m_compare = 32'h0;
            m_ti      = 1'b0;
            m_ok      = 1'b1;
        end else if (m_ok) begin
            hw = HWInt;
`ifdef CP0_TIMER_EN
            hw[5] = hw[5] | m_ti;
`endif
            ir = ((hw & m_sr[15:10]) != 6'h0) && m_sr[0] && !m_sr[1];
            er = (ExcCodeIn != 5'd0) && !m_sr[1];
            rq = ir || er;
            check("req", {31'b0, Req}, {31'b0, rq});
            check("epcout", EPCOut, m_epc);
            check("dout", Dout, m_read(A1));

            nsr = m_sr; ncause = m_cause; nepc = m_epc;
            ncause[15:10] = hw;
            if (rq) begin
                nsr[1]       = 1'b1;
                ncause[31]   = BDIn;
                ncause[6:2]  = ir ? 5'd0 : ExcCodeIn;
                vict         = BDIn ? VPC - 32'd4 : VPC;
                nepc         = vict & 32'hFFFF_FFFC;
            end else begin
                if (we && A2 == 5'd12) nsr = Din & SR_MASK;
                if (we && A2 == 5'd14) nepc = Din;
                if (EXLClr) nsr[1] = 1'b0;
            end
            wr       = we && !rq;
            ncount   = (wr && A2 == 5'd9) ? Din : m_count + 32'd1;
            ncompare = m_compare;
            nti      = m_ti;
            if (wr && A2 == 5'd11) begin
                ncompare = Din;
                nti      = 1'b0;
            end else if (m_count == m_compare && m_compare != 32'h0) begin
                nti = 1'b1;
            end
            m_sr = nsr; m_cause = ncause; m_epc = nepc;
            m_count = ncount; m_compare = ncompare; m_ti = nti;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        A1 = 5'd0; A2 = 5'd0; Din = 32'h0; we = 1'b0; VPC = 32'h0;
        BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'h0; EXLClr = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
        A1 = a;
        #1;
        check(name, Dout, exp);
    endtask

    initial begin
        logic found;
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        rd(5'd12, 32'h0, "rst_sr");
        rd(5'd13, 32'h0, "rst_cause");
        rd(5'd14, 32'h0, "rst_epc");
        rd(5'd15, PRID,  "rst_prid");
        check("rst_req", {31'b0, Req}, 32'h0);
        check("rst_epcout", EPCOut, 32'h0);

        // Enabled interrupt on line 2
        we = 1'b1; A2 = 5'd12; Din = 32'h0000_FC01;
        cyc();
        we = 1'b0; Din = 32'h0; HWInt = 6'b000100; VPC = 32'h0000_1000;
        #1;
        check("int_req", {31'b0, Req}, 32'h1);
        cyc();
        rd(5'd13, 32'h0000_1000, "int_cause");
        rd(5'd12, 32'h0000_FC03, "int_sr_exl");
        check("int_epc", EPCOut, 32'h0000_1000);
        check("int_req_masked", {31'b0, Req}, 32'h0);

        // Syscall in delay slot
        HWInt = 6'h0; EXLClr = 1'b1;
        cyc();
        EXLClr = 1'b0; ExcCodeIn = 5'd8; VPC = 32'h0000_3010; BDIn = 1'b1;
        #1;
        check("sys_req", {31'b0, Req}, 32'h1);
        cyc();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        rd(5'd13, 32'h8000_0020, "sys_cause");
        check("sys_epc", EPCOut, 32'h0000_300C);

        // Interrupt beats RI; simultaneous mtc0 EPC dropped
        EXLClr = 1'b1;
        cyc();
        EXLClr = 1'b0; ExcCodeIn = 5'd10; HWInt = 6'b000001;
        we = 1'b1; A2 = 5'd14; Din = 32'h0000_1234; VPC = 32'h0000_2000;
        #1;
        check("prio_req", {31'b0, Req}, 32'h1);
        cyc();
        ExcCodeIn = 5'd0; HWInt = 6'h0; we = 1'b0;
        rd(5'd13, 32'h0000_0400, "prio_cause");
        check("prio_epc", EPCOut, 32'h0000_2000);

        // eret then mtc0 EPC
        EXLClr = 1'b1;
        cyc();
        EXLClr = 1'b0;
        rd(5'd12, 32'h0000_FC01, "eret_sr");
        we = 1'b1; A2 = 5'd14; Din = 32'h0000_3400;
        cyc();
        we = 1'b0;
        check("mtc0_epc", EPCOut, 32'h0000_3400);

        // VPC wrap in delay slot
        ExcCodeIn = 5'd12; VPC = 32'h0; BDIn = 1'b1;
        cyc();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        check("wrap_epc", EPCOut, 32'hFFFF_FFFC);
        rd(5'd13, 32'h8000_0030, "ov_cause");
        EXLClr = 1'b1;
        cyc();
        EXLClr = 1'b0;

`ifdef CP0_TIMER_EN
        we = 1'b1; A2 = 5'd12; Din = 32'h0000_8001;
        cyc();
        A2 = 5'd9; Din = 32'h0;
        cyc();
        A2 = 5'd11; Din = 32'd5;
        cyc();
        we = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            #1;
            if (Req) found = 1'b1;
            else cyc();
        end
        check("timer_req", {31'b0, found}, 32'h1);
        cyc();
        EXLClr = 1'b1; we = 1'b1; A2 = 5'd11; Din = 32'h0;
        cyc();
        EXLClr = 1'b0; we = 1'b0;
        cyc();
        A1 = 5'd13;
        #1;
        check("timer_ti_clr", Dout & 32'h0000_8000, 32'h0);
        check("timer_req_clr", {31'b0, Req}, 32'h0);
`else
        found = 1'b0;
        we = 1'b1; A2 = 5'd11; Din = 32'd5;
        cyc();
        we = 1'b0;
        rd(5'd11, 32'h0, "no_compare");
        rd(5'd9, 32'h0, "no_count");
        check("no_timer_found", {31'b0, found}, 32'h0);
`endif

        // Randomized traffic
        reset = 1'b1;
        idle();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom % 600 == 0);
            case ($urandom % 8)
                0: A1 = 5'd9;   1: A1 = 5'd11;  2: A1 = 5'd12;  3: A1 = 5'd13;
                4: A1 = 5'd14;  5: A1 = 5'd15;  default: A1 = 5'($urandom);
            endcase
            case ($urandom % 8)
                0: A2 = 5'd9;   1: A2 = 5'd11;  2, 3: A2 = 5'd12;  4: A2 = 5'd13;
                5: A2 = 5'd14;  6: A2 = 5'd15;  default: A2 = 5'($urandom);
            endcase
            we        = ($urandom % 3 == 0);
            Din       = ($urandom % 2 == 0) ? 32'($urandom % 16) : 32'($urandom);
            VPC       = 32'($urandom);
            BDIn      = 1'($urandom);
            ExcCodeIn = ($urandom % 6 == 0) ? 5'($urandom) : 5'd0;
            HWInt     = ($urandom % 4 == 0) ? 6'($urandom) : 6'h0;
            EXLClr    = ($urandom % 5 == 0);
            cyc();
        end
        reset = 1'b0;
        idle();
        cyc();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
